// File: rtl/u_cla_pkg.sv
// u_cla_pkg: shared FSM state type and slice width for the nibble-serial adder
package u_cla_pkg;
  localparam int SLICE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/u_cla_slice4.sv
// u_cla_slice4: combinational 4-bit carry-lookahead adder slice
module u_cla_slice4
  import u_cla_pkg::*;
(
  input  logic               cin,
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);
  logic [SLICE_W-1:0] p, g, c;
  assign p = a ^ b;
  assign g = a & b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign sum = p ^ c;
endmodule

// File: rtl/u_cla_seq_ctrl.sv
// u_cla_seq_ctrl: two-requester round-robin front end for a nibble-serial CLA adder
module u_cla_seq_ctrl
  import u_cla_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W:0]   rsp_sum
);
  localparam int N = W / SLICE_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [W:0] sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic id_q, id_d, cy_q, cy_d, rr_q, rr_d;
  logic gnt_any, gnt_id, accept;
  logic [SLICE_W-1:0] s_a, s_b, s_sum;
  logic s_cout;
  // rr_q names the requester favoured when both are valid
  assign gnt_any = req0_valid | req1_valid;
  assign gnt_id = (req0_valid & req1_valid) ? rr_q : req1_valid;
  assign accept = (state_q == IDLE) & gnt_any & ~rst;
  assign req0_ready = accept & ~gnt_id;
  assign req1_ready = accept & gnt_id;
  assign s_a = a_q[idx_q*SLICE_W +: SLICE_W];
  assign s_b = b_q[idx_q*SLICE_W +: SLICE_W];
  u_cla_slice4 u_slice (
    .cin  (cy_q),
    .a    (s_a),
    .b    (s_b),
    .sum  (s_sum),
    .cout (s_cout)
  );
  assign rsp_valid = (state_q == DONE);
  assign rsp_id = id_q;
  assign rsp_sum = sum_q;
  // Next-state: grant in IDLE, one nibble per RUN cycle, hold result in DONE
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    idx_d = idx_q;
    id_d = id_q;
    cy_d = cy_q;
    rr_d = rr_q;
    if (state_q == IDLE && gnt_any) begin
      state_d = RUN;
      a_d = gnt_id ? req1_a : req0_a;
      b_d = gnt_id ? req1_b : req0_b;
      id_d = gnt_id;
      rr_d = ~gnt_id;
      cy_d = 1'b0;
      idx_d = '0;
    end
    if (state_q == RUN) begin
      sum_d[idx_q*SLICE_W +: SLICE_W] = s_sum;
      cy_d = s_cout;
      if (idx_q == LAST) begin
        sum_d[W] = s_cout;
        state_d = DONE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    if (state_q == DONE && rsp_ready) state_d = IDLE;
  end
  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      idx_q <= '0;
      id_q <= 1'b0;
      cy_q <= 1'b0;
      rr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      idx_q <= idx_d;
      id_q <= id_d;
      cy_q <= cy_d;
      rr_q <= rr_d;
    end
  end
endmodule

// File: tb/tb_u_cla_seq_ctrl.sv
// tb_u_cla_seq_ctrl: directed self-checking bench for the nibble-serial CLA controller
module tb_u_cla_seq_ctrl;
  localparam int W = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [W:0] rsp_sum;
  int total = 0, bad = 0;
  logic last_id;
  u_cla_seq_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_grant(input string tag, input logic exp_id);
    int n = 0;
    #1;
    while (!(req0_ready || req1_ready) && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk({tag, "_grant_seen"}, 32'(n < 20), 32'd1);
    chk({tag, "_grant_id"}, {30'd0, req1_ready, req0_ready}, exp_id ? 32'd2 : 32'd1);
    tick();
  endtask
  task automatic wait_rsp(input string tag, input logic exp_id, input logic [W:0] exp_sum);
    int n = 0;
    #1;
    while (!rsp_valid && n < 20) begin
      chk({tag, "_run_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
      #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(W / 4));
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(exp_id));
    chk({tag, "_rsp_sum"}, 32'(rsp_sum), 32'(exp_sum));
  endtask
  initial begin
    req0_valid = 1'b1;
    #3;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_sum", 32'(rsp_sum), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    req0_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'h0001;
    wait_grant("t1", 1'b0);
    req0_valid = 1'b0;
    wait_rsp("t1", 1'b0, 17'h10000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req0_a = 16'h1234 + 16'(k); req0_b = 16'h0FFF;
      req1_a = 16'hABCD; req1_b = 16'h5433 + 16'(k);
      wait_grant("t2", k[0]);
      wait_rsp("t2", k[0], k[0] ? 17'h10000 + 17'(k) : 17'h02233 + 17'(k));
      tick();
    end
    req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = 16'h00FF; req0_b = 16'h0F01;
    wait_grant("t3", 1'b0);
    wait_rsp("t3", 1'b0, 17'h01000);
    req1_valid = 1'b1; req1_a = 16'h7000; req1_b = 16'h1000;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("t3_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t3_hold_sum", 32'(rsp_sum), 32'h01000);
      chk("t3_hold_id", 32'(rsp_id), 32'd0);
      chk("t3_hold_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("t3_hs_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    rsp_ready = 1'b0;
    wait_grant("t3b", 1'b1);
    wait_rsp("t3b", 1'b1, 17'h08000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; req1_valid = 1'b0;
    req0_a = 16'hF0F0; req0_b = 16'h0F0F;
    wait_grant("t4", 1'b0);
    req0_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("t4_rst_valid", 32'(rsp_valid), 32'd0);
    chk("t4_rst_sum", 32'(rsp_sum), 32'd0);
    chk("t4_rst_id", 32'(rsp_id), 32'd0);
    chk("t4_rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t4_no_rsp", 32'(rsp_valid), 32'd0);
    end
    req1_valid = 1'b1; req1_a = 16'h1234; req1_b = 16'h4321;
    wait_grant("t4b", 1'b1);
    wait_rsp("t4b", 1'b1, 17'h05555);
    rsp_ready = 1'b1;
    tick();
    req1_a = 16'h8000; req1_b = 16'h8000;
    for (int k = 0; k < 2; k++) begin
      wait_grant("t5", 1'b1);
      wait_rsp("t5", 1'b1, 17'h10000);
      tick();
    end
    req1_valid = 1'b0; rsp_ready = 1'b0;
    last_id = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      int v, idle, hold;
      logic exp_id;
      logic [W:0] exp_sum;
      req0_valid = 1'b0; req1_valid = 1'b0;
      idle = $urandom_range(0, 2);
      for (int j = 0; j < idle; j++) begin
        #1;
        chk("rnd_idle_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        tick();
      end
      v = $urandom_range(1, 3);
      req0_a = 16'($urandom); req0_b = 16'($urandom);
      req1_a = 16'($urandom); req1_b = 16'($urandom);
      req0_valid = v[0]; req1_valid = v[1];
      exp_id = (v == 3) ? ~last_id : v[1];
      exp_sum = exp_id ? {1'b0, req1_a} + {1'b0, req1_b} : {1'b0, req0_a} + {1'b0, req0_b};
      last_id = exp_id;
      wait_grant("rnd", exp_id);
      req0_a = 16'($urandom); req1_b = 16'($urandom);
      wait_rsp("rnd", exp_id, exp_sum);
      hold = $urandom_range(0, 2);
      for (int j = 0; j < hold; j++) tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
